// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB pipeline stage.
// Holds the FSM state encoding, datapath widths, the fault writeback value,
// and the latched memory-operation context.
package mem_wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] FAULT_DATA = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Everything needed to retire a memory op once the EX/MEM register has moved on
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [REG_W-1:0]  dst;
    logic              regwrite;
    logic              pcs;
    logic              memtoreg;
    logic              is_write;
  } op_ctx_t;

  // Register 0 is hardwired, so a write to it never reaches the register file
  function automatic logic gate_regwrite(input logic regwrite, input logic [REG_W-1:0] dst);
    return regwrite && (dst != '0);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM inputs, memory request/response and MEM/WB outputs.
// master: the MEM/WB stage itself. slave: the surrounding pipeline and memory.
interface mem_wb_stage_if;

  // EX/MEM register contents
  logic                          ex_valid;
  logic [mem_wb_pkg::DATA_W-1:0] ex_alu_out;
  logic [mem_wb_pkg::DATA_W-1:0] ex_wdata;
  logic                          ex_memwrite;
  logic                          ex_memread;
  logic                          ex_memtoreg;
  logic                          ex_pcs;
  logic                          ex_regwrite;
  logic [mem_wb_pkg::REG_W-1:0]  ex_dst;
  logic [mem_wb_pkg::REG_W-1:0]  ex_src_st;

  // Pipeline hold
  logic                          stall;

  // Memory request / response
  logic                          mem_en;
  logic                          mem_wr;
  logic [mem_wb_pkg::DATA_W-1:0] mem_addr;
  logic [mem_wb_pkg::DATA_W-1:0] mem_wdata;
  logic [mem_wb_pkg::DATA_W-1:0] mem_rdata;
  logic                          mem_valid;

  // MEM/WB register
  logic                          wb_valid;
  logic                          wb_regwrite;
  logic                          wb_pcs;
  logic [mem_wb_pkg::DATA_W-1:0] wb_data;
  logic [mem_wb_pkg::REG_W-1:0]  wb_dst;

  logic                          err;

  modport master (
    input  ex_valid, ex_alu_out, ex_wdata, ex_memwrite, ex_memread,
           ex_memtoreg, ex_pcs, ex_regwrite, ex_dst, ex_src_st,
           mem_rdata, mem_valid,
    output stall, mem_en, mem_wr, mem_addr, mem_wdata,
           wb_valid, wb_regwrite, wb_pcs, wb_data, wb_dst, err
  );

  modport slave (
    output ex_valid, ex_alu_out, ex_wdata, ex_memwrite, ex_memread,
           ex_memtoreg, ex_pcs, ex_regwrite, ex_dst, ex_src_st,
           mem_rdata, mem_valid,
    input  stall, mem_en, mem_wr, mem_addr, mem_wdata,
           wb_valid, wb_regwrite, wb_pcs, wb_data, wb_dst, err
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Counts WAIT cycles without a memory response.
// tc is high during the cycle whose increment would bring the count to
// TIMEOUT, so the owner can abort on that same clock edge.
module mem_wait_counter
  import mem_wb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count_reg;

  // Wait-cycle counter; clear wins over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one memory request per load/store, stalls the
// pipeline until the memory answers (or a wait timeout fires), and drives the
// MEM/WB register. ALU-only instructions pass straight through in one cycle.
// Optional store-data forwarding from the MEM/WB register: define MEM_WB_FWD_EN.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.master bus
);

  state_t            state_reg;
  op_ctx_t           ctx_reg;
  logic              wb_valid_reg;
  logic              wb_regwrite_reg;
  logic              wb_pcs_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [REG_W-1:0]  wb_dst_reg;
  logic              err_reg;

  logic              in_idle;
  logic              mem_op;
  logic              issue;
  logic              tc;
  logic [DATA_W-1:0] store_data;

  assign in_idle = (state_reg == IDLE);
  assign mem_op  = bus.ex_valid && (bus.ex_memread || bus.ex_memwrite);
  assign issue   = in_idle && mem_op;

`ifdef MEM_WB_FWD_EN
  // Store data may come from the instruction just retired into MEM/WB
  assign store_data = (wb_valid_reg && wb_regwrite_reg &&
                       (wb_dst_reg == bus.ex_src_st) && (bus.ex_src_st != '0))
                      ? wb_data_reg : bus.ex_wdata;
`else
  logic unused_src_st;
  assign unused_src_st = ^bus.ex_src_st;
  assign store_data    = bus.ex_wdata;
`endif

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_idle),
    .enable (!in_idle && !bus.mem_valid),
    .tc     (tc)
  );

  // Same-cycle request and stall; held at zero while reset is asserted
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.stall     = 1'b0;
    if (rst) begin
      if (issue) begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = bus.ex_memwrite;
        bus.mem_addr  = bus.ex_alu_out;
        bus.mem_wdata = store_data;
        bus.stall     = 1'b1;
      end else if (!in_idle && !bus.mem_valid && !tc) begin
        // The timeout cycle releases the stall: the op retires with a fault
        bus.stall = 1'b1;
      end
    end
  end

  // FSM, op-context latch, MEM/WB register and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      ctx_reg         <= '0;
      wb_valid_reg    <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_pcs_reg      <= 1'b0;
      wb_data_reg     <= '0;
      wb_dst_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A response with nothing outstanding is a protocol fault
          if (bus.mem_valid) begin
            err_reg <= 1'b1;
          end
          if (!bus.ex_valid) begin
            wb_valid_reg <= 1'b0;
          end else if (!mem_op) begin
            wb_valid_reg    <= 1'b1;
            wb_data_reg     <= bus.ex_alu_out;
            wb_dst_reg      <= bus.ex_dst;
            wb_regwrite_reg <= gate_regwrite(bus.ex_regwrite, bus.ex_dst);
            wb_pcs_reg      <= bus.ex_pcs;
          end else begin
            ctx_reg.alu_out  <= bus.ex_alu_out;
            ctx_reg.dst      <= bus.ex_dst;
            ctx_reg.regwrite <= bus.ex_regwrite;
            ctx_reg.pcs      <= bus.ex_pcs;
            ctx_reg.memtoreg <= bus.ex_memtoreg;
            ctx_reg.is_write <= bus.ex_memwrite;
            // Read+write together is ambiguous; it is issued as a write
            if (bus.ex_memread && bus.ex_memwrite) begin
              err_reg <= 1'b1;
            end
            wb_valid_reg <= 1'b0;
            state_reg    <= WAIT;
          end
        end

        WAIT: begin
          if (bus.mem_valid) begin
            wb_valid_reg    <= 1'b1;
            wb_data_reg     <= ctx_reg.memtoreg ? bus.mem_rdata : ctx_reg.alu_out;
            wb_dst_reg      <= ctx_reg.dst;
            wb_regwrite_reg <= !ctx_reg.is_write &&
                               gate_regwrite(ctx_reg.regwrite, ctx_reg.dst);
            wb_pcs_reg      <= ctx_reg.pcs;
            state_reg       <= IDLE;
          end else if (tc) begin
            err_reg         <= 1'b1;
            wb_valid_reg    <= 1'b1;
            wb_data_reg     <= FAULT_DATA;
            wb_dst_reg      <= ctx_reg.dst;
            wb_regwrite_reg <= 1'b0;
            wb_pcs_reg      <= ctx_reg.pcs;
            state_reg       <= IDLE;
          end else begin
            wb_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          wb_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_valid    = wb_valid_reg;
  assign bus.wb_regwrite = wb_regwrite_reg;
  assign bus.wb_pcs      = wb_pcs_reg;
  assign bus.wb_data     = wb_data_reg;
  assign bus.wb_dst      = wb_dst_reg;
  assign bus.err         = err_reg;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT, 15, max WAIT cycles before abort (range 2..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, all state on rising edge
 rst  in  1  reset, asynchronous, active-low
 ex_valid  in  1  EX/MEM register holds a live instruction
 ex_alu_out  in  16  ALU result / memory address
 ex_wdata  in  16  store data
 ex_memwrite, ex_memread, ex_memtoreg, ex_pcs, ex_regwrite  in  1 each  propagated controls
 ex_dst  in  4  destination register
 ex_src_st  in  4  store-data source register
 stall  out  1  hold EX/MEM register and all upstream stages
 mem_en  out  1  one-cycle memory request strobe
 mem_wr  out  1  request is a write
 mem_addr  out  16  request address
 mem_wdata  out  16  request write data
 mem_rdata  in  16  read data, valid with mem_valid
 mem_valid  in  1  one-cycle completion from memory
 wb_valid, wb_regwrite, wb_pcs  out  1 each  MEM/WB register controls
 wb_data  out  16  writeback value
 wb_dst  out  4  writeback register
 err  out  1  sticky fault flag

Function
REQ-003 SHALL implement FSM states IDLE and WAIT.
REQ-004 IDLE, ex_valid=0: stall=0, mem_en=0; at edge wb_valid<=0.
REQ-005 IDLE, ex_valid=1, no memread/memwrite: stall=0; at edge wb_valid<=1, wb_data<=ex_alu_out, wb_dst/wb_regwrite/wb_pcs<=inputs (latency 1).
REQ-006 IDLE, ex_valid=1 with memread or memwrite: same cycle mem_en=1, mem_wr=ex_memwrite, mem_addr=ex_alu_out, mem_wdata=store data (REQ-014), stall=1; at edge latch op context, go WAIT, wb_valid<=0.
REQ-007 WAIT without mem_valid: stall=1, mem_en=0, wait counter increments; wb_valid<=0.
REQ-008 WAIT with mem_valid: stall=0 that cycle; at edge go IDLE, wb_valid<=1, wb_data<=(memtoreg ? mem_rdata : latched alu_out), latched dst/regwrite/pcs; store writes wb_regwrite<=0.
REQ-009 Total memory-op latency = memory latency + 1 cycles; stall high exactly from request cycle through last non-completion WAIT cycle.
REQ-010 Counter reaching TIMEOUT in WAIT without mem_valid: at edge err<=1, go IDLE, wb_valid<=1, wb_regwrite<=0, wb_data<=16'hFFFF; mem_valid on the timeout cycle takes priority (normal completion, no err).
REQ-011 ex_memread=ex_memwrite=1: treated as write, err<=1 at request edge.
REQ-012 mem_valid in IDLE SHALL be ignored and set err.
REQ-013 Writes to wb_dst=0 SHALL force wb_regwrite=0.

Reset
REQ-015 rst low SHALL immediately force IDLE, counter=0, stall=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, all wb_* =0, err=0, including mid-WAIT; late mem_valid after reset handled by REQ-012.

Configuration
REQ-014 Macro MEM_WB_FWD_EN defined: store data = wb_data when wb_valid & wb_regwrite & wb_dst==ex_src_st & ex_src_st!=0, else ex_wdata. Undefined: store data = ex_wdata always; ex_src_st unused but port retained.

Structure
REQ-016 Package mem_wb_pkg SHALL hold state enum (IDLE, WAIT), data width 16, register-id width 4, fault data 16'hFFFF.
REQ-017 Sub-module mem_wait_counter (clear, enable, terminal-count flag at TIMEOUT) SHALL implement the wait counter.

Verification
REQ-018 ALU op ex_alu_out=16'h1234, dst=3, regwrite=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_dst=3, stall never high.
REQ-019 Load addr 16'h0040, memory returns 16'hBEEF after 3 WAIT cycles -> mem_en single pulse, stall high 4 cycles, wb_data=16'hBEEF, wb_regwrite=1.
REQ-020 Store addr 16'h0010 data 16'h00AA -> mem_wr=1, mem_wdata=16'h00AA, wb_valid=1 with wb_regwrite=0.
REQ-021 No mem_valid for TIMEOUT=15 cycles -> err=1, wb_data=16'hFFFF, wb_regwrite=0, back to IDLE, err stays high.
REQ-022 rst low during WAIT -> all outputs 0 immediately; next load completes normally.
REQ-023 With MEM_WB_FWD_EN: load r5<=16'h7777 then store src r5, ex_wdata=0 -> mem_wdata=16'h7777; without macro -> 16'h0000.
